fir_ctrl: RTL and testbench

Sequencer for the 32-tap FIR datapath. It accepts one input sample per handshake and pulses the shift enable of the 32x16 sample shift RAM. It then sweeps the RAM read address and the coefficient address over all taps and drives the MAC enable and clear, aligned to the RAM's 1-cycle registered read. It flags completion with result_valid and records dropped samples in a sticky overrun flag.

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_ctrl.sv | 106 ++++++++++
 tb/tb_fir_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the 32-tap FIR sequencer.
package fir_pkg;

    localparam int DEF_TAPS   = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int LAST_TAP   = DEF_TAPS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fir_ctrl.sv
// FIR sequencer: accepts a sample, sweeps taps, drives MAC enables
// aligned to the one-cycle registered read of the sample RAM.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              abort,
    input  logic              clr_overrun,
    output logic              data_in_en,
    output logic [ADDR_W-1:0] data_counter,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              result_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] C_ZERO = '0;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;
    logic              r_mac_en;
    logic              r_mac_clr;
    logic              r_result_valid;
    logic              r_overrun;
    logic              w_ready;
    logic              w_accept;
    logic              w_run;

    assign w_ready  = (r_state == IDLE);
    // abort outranks a sample arriving in IDLE, so no shift either
    assign w_accept = w_ready & sample_valid & ~abort;
    assign w_run    = (r_state == RUN);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next     = RUN;
                    w_cnt_next = C_ZERO;
                end
            end
            RUN: begin
                if (r_cnt == C_LAST) begin
                    w_next     = DRAIN;
                    w_cnt_next = C_ZERO;
                end else begin
                    w_cnt_next = r_cnt + ADDR_W'(1);
                end
            end
            DRAIN:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort) begin
            w_next     = IDLE;
            w_cnt_next = C_ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= C_ZERO;
            r_mac_en       <= 1'b0;
            r_mac_clr      <= 1'b0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            // one-cycle delay matches the RAM read latency
            r_mac_en  <= w_run & ~abort;
            r_mac_clr <= w_run & (r_cnt == C_ZERO) & ~abort;
            r_result_valid <= (r_state == DRAIN) & ~abort;
            if (sample_valid & ~w_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sample_ready = w_ready;
    assign data_in_en   = w_accept;
    assign data_counter = r_cnt;
    assign coef_addr    = r_cnt;
    assign mac_en       = r_mac_en;
    assign mac_clr      = r_mac_clr;
    assign result_valid = r_result_valid;
    assign busy         = ~w_ready;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural sample RAM and MAC.
module tb_fir_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic        sample_ready;
    logic        abort;
    logic        clr_overrun;
    logic        data_in_en;
    logic [4:0]  data_counter;
    logic [4:0]  coef_addr;
    logic        mac_en;
    logic        mac_clr;
    logic        result_valid;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    fir_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .abort        (abort),
        .clr_overrun  (clr_overrun),
        .data_in_en   (data_in_en),
        .data_counter (data_counter),
        .coef_addr    (coef_addr),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // surrounding datapath: shift RAM, registered read, unit coefs, MAC
    logic signed [15:0] din;
    logic signed [15:0] ram [32];
    logic signed [15:0] ram_q;
    logic signed [31:0] acc;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        ram_q = '0;
        acc   = '0;
    end

    always @(posedge clk) begin
        if (data_in_en) begin
            for (int i = 31; i > 0; i--) ram[i] <= ram[i-1];
            ram[0] <= din;
        end
        ram_q <= ram[data_counter];
        if (mac_en) begin
            if (mac_clr) acc <= 32'(ram_q);
            else         acc <= acc + 32'(ram_q);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        sample_valid = 1'b0;
        abort        = 1'b0;
        clr_overrun  = 1'b0;
    endtask

    int n_acc;
    int n_rv;
    int waited;
    bit exp_ovr;

    initial begin
        rst_n = 1'b0;
        din   = '0;
        idle_inputs();

        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        nxt();
        settle();
        chk("idle_ready", 32'(sample_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_cnt", 32'(data_counter), 0);
        chk("idle_coef", 32'(coef_addr), 0);
        chk("idle_macen", 32'(mac_en), 0);
        chk("idle_macclr", 32'(mac_clr), 0);
        chk("idle_rv", 32'(result_valid), 0);
        chk("idle_ovr", 32'(overrun), 0);
        chk("idle_shift", 32'(data_in_en), 0);

        // single sample timeline, accepted in cycle 0
        nxt();
        sample_valid = 1'b1;
        settle();
        chk("s_shift0", 32'(data_in_en), 1);
        for (int c = 1; c <= 35; c++) begin
            nxt();
            sample_valid = 1'b0;
            settle();
            chk($sformatf("s_cnt%0d", c), 32'(data_counter),
                (c >= 1 && c <= 32) ? 32'(c - 1) : 0);
            chk($sformatf("s_coef%0d", c), 32'(coef_addr),
                (c >= 1 && c <= 32) ? 32'(c - 1) : 0);
            chk($sformatf("s_macen%0d", c), 32'(mac_en),
                32'(c >= 2 && c <= 33));
            chk($sformatf("s_macclr%0d", c), 32'(mac_clr),
                32'(c == 2));
            chk($sformatf("s_rv%0d", c), 32'(result_valid),
                32'(c == 34));
            chk($sformatf("s_rdy%0d", c), 32'(sample_ready),
                32'(c == 35));
            chk($sformatf("s_shift%0d", c), 32'(data_in_en), 0);
        end

        // back-to-back: sample_valid held high; cycle 35 above is cycle 0
        n_acc = 0;
        n_rv  = 0;
        sample_valid = 1'b1;
        for (int c = 0; c < 105; c++) begin
            if (c > 0) nxt();
            sample_valid = 1'b1;
            settle();
            if (data_in_en) n_acc++;
            if (result_valid) n_rv++;
            chk($sformatf("b_shift%0d", c), 32'(data_in_en),
                32'(c % 35 == 0));
            chk($sformatf("b_ovr%0d", c), 32'(overrun),
                32'(c >= 2));
        end
        chk("b_accepts", 32'(n_acc), 3);
        chk("b_results", 32'(n_rv), 3);
        nxt();
        sample_valid = 1'b0;
        clr_overrun  = 1'b1;
        settle();
        chk("b_idle_ready", 32'(sample_ready), 1);
        nxt();
        clr_overrun = 1'b0;
        settle();
        chk("b_ovr_clr", 32'(overrun), 0);

        // overrun set/clear during a run; this cycle is cycle 0
        sample_valid = 1'b1;
        settle();
        chk("o_shift0", 32'(data_in_en), 1);
        for (int c = 1; c <= 35; c++) begin
            nxt();
            idle_inputs();
            if (c == 10 || c == 22 || c == 25) sample_valid = 1'b1;
            if (c == 20 || c == 25 || c == 27) clr_overrun = 1'b1;
            settle();
            exp_ovr = (c >= 11 && c <= 20) || (c >= 23 && c <= 27);
            chk($sformatf("o_ovr%0d", c), 32'(overrun), 32'(exp_ovr));
            chk($sformatf("o_shift%0d", c), 32'(data_in_en), 0);
            chk($sformatf("o_rv%0d", c), 32'(result_valid),
                32'(c == 34));
        end
        nxt();
        idle_inputs();
        settle();
        chk("o_ready", 32'(sample_ready), 1);

        // abort in cycle 15, fresh sample in cycle 16
        sample_valid = 1'b1;
        settle();
        chk("a_shift0", 32'(data_in_en), 1);
        for (int c = 1; c <= 50; c++) begin
            nxt();
            idle_inputs();
            if (c == 15) abort = 1'b1;
            if (c == 16) sample_valid = 1'b1;
            settle();
            if (c == 16) begin
                chk("a_ready16", 32'(sample_ready), 1);
                chk("a_cnt16", 32'(data_counter), 0);
                chk("a_busy16", 32'(busy), 0);
                chk("a_shift16", 32'(data_in_en), 1);
            end
            if (c >= 16 && c <= 17)
                chk($sformatf("a_macen%0d", c), 32'(mac_en), 0);
            chk($sformatf("a_rv%0d", c), 32'(result_valid),
                32'(c == 50));
        end

        // abort with sample in IDLE: abort wins
        nxt();
        idle_inputs();
        sample_valid = 1'b1;
        abort        = 1'b1;
        settle();
        chk("ai_shift", 32'(data_in_en), 0);
        nxt();
        idle_inputs();
        settle();
        chk("ai_busy", 32'(busy), 0);
        chk("ai_ovr", 32'(overrun), 0);

        // reset in the middle of a run
        sample_valid = 1'b1;
        nxt();
        idle_inputs();
        repeat (8) nxt();
        rst_n = 1'b0;
        #1;
        chk("r_busy", 32'(busy), 0);
        chk("r_cnt", 32'(data_counter), 0);
        chk("r_macen", 32'(mac_en), 0);
        nxt();
        rst_n = 1'b1;
        n_rv = 0;
        for (int c = 0; c < 40; c++) begin
            nxt();
            settle();
            if (result_valid) n_rv++;
        end
        chk("r_no_result", 32'(n_rv), 0);

        // end to end: impulse of 1000 then zeros, unit coefficients
        for (int k = 0; k < 34; k++) begin
            waited = 0;
            while (!sample_ready && waited < 50) begin
                nxt();
                waited++;
            end
            chk($sformatf("e_wait_rdy%0d", k), 32'(waited < 50), 1);
            sample_valid = 1'b1;
            din = (k == 0) ? 16'sd1000 : 16'sd0;
            nxt();
            sample_valid = 1'b0;
            din = '0;
            waited = 0;
            settle();
            while (!result_valid && waited < 50) begin
                nxt();
                settle();
                waited++;
            end
            chk($sformatf("e_wait_rv%0d", k), 32'(waited < 50), 1);
            chk($sformatf("e_result%0d", k), 32'(acc),
                (k < 32) ? 32'd1000 : 32'd0);
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
